anton_neopixel_frame_sequencer: RTL
===================================

// Module: anton_neopixel_frame_sequencer
// PURPOSE
//  Sequences anton_neopixel_stream_logic frame by frame: init pulse, run control, frame counting,
//  loop/one-shot and graceful stop. Arbitrates pixel-buffer write access between the APB writer and
//  the stream: host writes are granted only outside the pixel-transmit phase, stalling the next frame if needed.
//  Sits between the register block (ctrl pulses) and the stream logic (regCtrlInit/regCtrlRun, initSlow).
// PARAMETERS
//  FRAME_BITS    8   width of frameCount/framesSent
//  INIT_TIMEOUT  15  clk6_4mhz cycles allowed from initSlow assert to initSlowDone; 1..255
// PORTS
//  clk6_4mhz      in   1           sole clock
//  rst            in   1           synchronous, active-high reset
//  ctrlStart      in   1           1-cycle pulse: begin sequence
//  ctrlStop       in   1           1-cycle pulse: stop after current frame's reset phase
//  ctrlLoop       in   1           1 = frames repeat until stop; 0 = send frameCount frames
//  frameCount     in   FRAME_BITS  frames per one-shot run; 0 treated as 1
//  initSlowDone   in   1           from stream logic
//  streamPixelOf  in   1           from stream logic: last bit of last pixel
//  streamSyncOf   in   1           from stream logic: reset delay complete
//  writeReq       in   1           level: APB bridge wants buffer; held until write burst done
//  initSlow       out  1           to stream logic
//  regCtrlInit    out  1           to stream logic; blocks output during init
//  regCtrlRun     out  1           to stream logic
//  writeGrant     out  1           buffer granted to APB writer
//  busy           out  1           state != IDLE
//  frameDone      out  1           1-cycle pulse per completed frame (on streamSyncOf)
//  framesSent     out  FRAME_BITS  frames completed since last start; wraps
//  errInit        out  1           sticky: init timeout; cleared by ctrlStart
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except writeGrant=1 (IDLE grants); stopPending=0, timeout cnt=0.
//  States (ENUM_SEQ_*): IDLE, INIT, TX, LATCH, HOLD.
//  IDLE: writeGrant=writeReq. ctrlStart & !writeReq -> INIT, framesSent<=0, errInit<=0, stopPending<=0.
//   ctrlStart while writeReq=1 is latched (startPending) and taken when writeReq drops. ctrlStop ignored.
//  INIT: initSlow=1, regCtrlInit=1, regCtrlRun=0 until initSlowDone sampled high -> TX.
//   Timeout counter reaches INIT_TIMEOUT first -> errInit<=1, IDLE.
//  TX: regCtrlRun=1, writeGrant=0. streamPixelOf -> LATCH.
//  LATCH: regCtrlRun=1 (stream counts reset delay); writeGrant=writeReq. On streamSyncOf:
//   frameDone=1, framesSent++; then priority: stopPending|ctrlStop -> IDLE;
//   !ctrlLoop & framesSent+1 >= max(frameCount,1) -> IDLE; writeReq -> HOLD; else -> TX.
//  HOLD: regCtrlRun=0, writeGrant=writeReq. ctrlStop -> IDLE; !writeReq -> TX (next cycle run=1).
//  regCtrlRun, regCtrlInit, initSlow registered from NEXT state, so run falls on the same edge the
//   stream logic leaves reset state: zero stray transmit cycles on stop/hold.
//  ctrlStop in INIT/TX/LATCH sets stopPending; frame never truncated. ctrlStart while busy ignored.
//  writeGrant is registered; drops in the cycle TX is entered, never rises during TX.
//  writeReq arriving during TX waits until LATCH (grant latency <= one frame).
//  Simultaneous streamSyncOf+ctrlStop: stop wins, frame still counted.
//  rst mid-frame: IDLE next edge, run=0; stream logic has no reset, so every start re-runs INIT.
// STRUCTURE
//  ENUM_SEQ_* state codes and INIT_TIMEOUT default go in anton_common.vh.
//  Single module; no sub-module (timeout counter and frame counter are inline, <=8 bits each).
// TESTING
//  One-shot: frameCount=3, loop=0, start -> exactly 3 frameDone pulses, framesSent=3, busy falls, run=0 after 3rd sync.
//  Loop+stop: loop=1, stop mid-TX of frame 2 -> frame 2 completes (pixelOf, syncOf), then IDLE; framesSent=2.
//  Write hold: writeReq raised during TX -> grant only in LATCH; held 50 cycles past sync -> HOLD, run=0 50 cycles, TX on release.
//  Init timeout: tie initSlowDone=0 -> errInit=1 after 15 cycles, IDLE; next start clears errInit.
//  Boundaries: frameCount=0 -> 1 frame; framesSent wraps 255->0 in loop; stop+sync same cycle -> IDLE, count++.
//  Reset mid-TX: rst pulse -> next cycle IDLE, run=0, grant=1; restart passes through INIT first.

Source files
------------

// File: rtl/anton_neopixel_frame_sequencer_pkg.sv
// Shared state encoding and default sizing for the NeoPixel frame sequencer.
package anton_neopixel_frame_sequencer_pkg;

    localparam int SEQ_FRAME_BITS   = 8;
    localparam int SEQ_INIT_TIMEOUT = 15;

    typedef enum logic [2:0] {
        ENUM_SEQ_IDLE  = 3'd0,
        ENUM_SEQ_INIT  = 3'd1,
        ENUM_SEQ_TX    = 3'd2,
        ENUM_SEQ_LATCH = 3'd3,
        ENUM_SEQ_HOLD  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/anton_neopixel_frame_sequencer.sv
// Frame-by-frame sequencer for the NeoPixel stream logic: init, run, frame counting,
// loop/one-shot, graceful stop, and pixel-buffer arbitration between APB writer and stream.
module anton_neopixel_frame_sequencer
    import anton_neopixel_frame_sequencer_pkg::*;
#(
    parameter int FRAME_BITS   = SEQ_FRAME_BITS,
    parameter int INIT_TIMEOUT = SEQ_INIT_TIMEOUT
) (
    input  logic                  clk6_4mhz,
    input  logic                  rst,
    input  logic                  ctrlStart,
    input  logic                  ctrlStop,
    input  logic                  ctrlLoop,
    input  logic [FRAME_BITS-1:0] frameCount,
    input  logic                  initSlowDone,
    input  logic                  streamPixelOf,
    input  logic                  streamSyncOf,
    input  logic                  writeReq,
    output logic                  initSlow,
    output logic                  regCtrlInit,
    output logic                  regCtrlRun,
    output logic                  writeGrant,
    output logic                  busy,
    output logic                  frameDone,
    output logic [FRAME_BITS-1:0] framesSent,
    output logic                  errInit
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(INIT_TIMEOUT - 1);

    seq_state_e            state_q, state_d;
    logic                  start_pending_q, start_pending_d;
    logic                  stop_pending_q, stop_pending_d;
    logic [7:0]            tmo_cnt_q, tmo_cnt_d;
    logic [FRAME_BITS-1:0] frames_q, frames_d;
    logic                  err_init_q, err_init_d;
    logic                  frame_done_q, frame_done_d;
    logic                  init_q, run_q, grant_q, busy_q;
    logic                  init_d, run_d, grant_d, busy_d;
    logic [FRAME_BITS:0]   frames_next_ext;
    logic [FRAME_BITS:0]   frame_target;

    // One extra bit so the one-shot end test is immune to the frame counter wrapping.
    assign frames_next_ext = {1'b0, frames_q} + {{FRAME_BITS{1'b0}}, 1'b1};
    assign frame_target    = (frameCount == '0) ? {{FRAME_BITS{1'b0}}, 1'b1}
                                                : {1'b0, frameCount};

    always_comb begin
        state_d         = state_q;
        start_pending_d = start_pending_q;
        stop_pending_d  = stop_pending_q;
        tmo_cnt_d       = tmo_cnt_q;
        frames_d        = frames_q;
        err_init_d      = err_init_q;
        frame_done_d    = 1'b0;

        case (state_q)
            ENUM_SEQ_IDLE: begin
                if (ctrlStart || start_pending_q) begin
                    if (writeReq) begin
                        start_pending_d = 1'b1;
                    end else begin
                        state_d         = ENUM_SEQ_INIT;
                        start_pending_d = 1'b0;
                        stop_pending_d  = 1'b0;
                        frames_d        = '0;
                        err_init_d      = 1'b0;
                        tmo_cnt_d       = '0;
                    end
                end
            end
            ENUM_SEQ_INIT: begin
                if (ctrlStop) stop_pending_d = 1'b1;
                if (initSlowDone) begin
                    state_d = ENUM_SEQ_TX;
                end else if (tmo_cnt_q == TIMEOUT_LAST) begin
                    err_init_d = 1'b1;
                    state_d    = ENUM_SEQ_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            ENUM_SEQ_TX: begin
                if (ctrlStop) stop_pending_d = 1'b1;
                if (streamPixelOf) state_d = ENUM_SEQ_LATCH;
            end
            ENUM_SEQ_LATCH: begin
                if (ctrlStop) stop_pending_d = 1'b1;
                if (streamSyncOf) begin
                    frame_done_d = 1'b1;
                    frames_d     = frames_q + 1'b1;
                    if (stop_pending_q || ctrlStop) begin
                        state_d = ENUM_SEQ_IDLE;
                    end else if (!ctrlLoop && (frames_next_ext >= frame_target)) begin
                        state_d = ENUM_SEQ_IDLE;
                    end else if (writeReq) begin
                        state_d = ENUM_SEQ_HOLD;
                    end else begin
                        state_d = ENUM_SEQ_TX;
                    end
                end
            end
            ENUM_SEQ_HOLD: begin
                if (ctrlStop) begin
                    state_d = ENUM_SEQ_IDLE;
                end else if (!writeReq) begin
                    state_d = ENUM_SEQ_TX;
                end
            end
            default: state_d = ENUM_SEQ_IDLE;
        endcase
    end

    // Stream controls follow the next state so they change on the same edge as the state.
    // The buffer stays with the stream from INIT onward so TX never starts under a host write.
    always_comb begin
        init_d  = (state_d == ENUM_SEQ_INIT);
        run_d   = (state_d == ENUM_SEQ_TX) || (state_d == ENUM_SEQ_LATCH);
        busy_d  = (state_d != ENUM_SEQ_IDLE);
        grant_d = 1'b0;
        if ((state_d == ENUM_SEQ_IDLE) || (state_d == ENUM_SEQ_LATCH) ||
            (state_d == ENUM_SEQ_HOLD)) begin
            grant_d = writeReq;
        end
    end

    always_ff @(posedge clk6_4mhz) begin
        if (rst) begin
            state_q         <= ENUM_SEQ_IDLE;
            start_pending_q <= 1'b0;
            stop_pending_q  <= 1'b0;
            tmo_cnt_q       <= '0;
            frames_q        <= '0;
            err_init_q      <= 1'b0;
            frame_done_q    <= 1'b0;
            init_q          <= 1'b0;
            run_q           <= 1'b0;
            busy_q          <= 1'b0;
            grant_q         <= 1'b1;
        end else begin
            state_q         <= state_d;
            start_pending_q <= start_pending_d;
            stop_pending_q  <= stop_pending_d;
            tmo_cnt_q       <= tmo_cnt_d;
            frames_q        <= frames_d;
            err_init_q      <= err_init_d;
            frame_done_q    <= frame_done_d;
            init_q          <= init_d;
            run_q           <= run_d;
            busy_q          <= busy_d;
            grant_q         <= grant_d;
        end
    end

    assign initSlow    = init_q;
    assign regCtrlInit = init_q;
    assign regCtrlRun  = run_q;
    assign writeGrant  = grant_q;
    assign busy        = busy_q;
    assign frameDone   = frame_done_q;
    assign framesSent  = frames_q;
    assign errInit     = err_init_q;

endmodule
